reaction_round_sched: RTL



---
 rtl/reaction_round_sched.sv | 272 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/reaction_round_sched.sv
// reaction_round_sched
// ----------------------------------------------------------------------------
// Sequences a multi-round reaction game. After a start request it runs a
// seconds countdown. Each round then waits a pseudo-random delay, raises the
// cue and times the player's reaction. Scores are accumulated round by round,
// and the final totals are held until the next start.
//
// Timing is driven by an internal tick enable. It fires once every TICK_DIV
// clocks (10 ms at 100 MHz). There is only one clock in this block.
//
// Optional feature (macro FALSE_START_PENALTY_EN):
//   undefined : a press while waiting for the cue ends the game at once.
//   defined   : a press while waiting for the cue scores the round as a
//               timeout penalty, and play continues.
//
// Ports:
//   clk           in   1   system clock
//   reset         in   1   synchronous, active-high
//   start         in   1   single-cycle start request (IDLE / FINISHED only)
//   btn           in   1   debounced button level
//   lfsr_in       in   9   free-running LFSR value used for the cue delay
//   phase         out  3   IDLE=0 COUNTDOWN=1 WAIT=2 REACT=3 RESULT=4 FINISHED=5
//   cue           out  1   high only while in REACT
//   countdown     out  3   seconds remaining in the countdown
//   round_idx     out  3   current round, 0-based
//   round_score   out  9   last round's score in ticks
//   round_timeout out  1   last round timed out (or was penalised)
//   early         out  1   a false start occurred
//   best_score    out  9   minimum non-timeout score (1FF when none yet)
//   total_score   out  11  sum of round scores
//   done          out  1   high while in FINISHED
module reaction_round_sched #(
    parameter int TICK_DIV     = 1000000,
    parameter int COUNTDOWN_S  = 5,
    parameter int ACTIVE_MIN   = 100,
    parameter int TIMEOUT      = 300,
    parameter int NUM_ROUNDS   = 3,
    parameter int RESULT_TICKS = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        btn,
    input  logic [8:0]  lfsr_in,
    output logic [2:0]  phase,
    output logic        cue,
    output logic [2:0]  countdown,
    output logic [2:0]  round_idx,
    output logic [8:0]  round_score,
    output logic        round_timeout,
    output logic        early,
    output logic [8:0]  best_score,
    output logic [10:0] total_score,
    output logic        done
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_WAIT      = 3'd2,
        ST_REACT     = 3'd3,
        ST_RESULT    = 3'd4,
        ST_FINISHED  = 3'd5
    } state_t;

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int RES_W  = (RESULT_TICKS > 1) ? $clog2(RESULT_TICKS) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST    = TICK_W'(TICK_DIV - 1);
    localparam logic [RES_W-1:0]  RES_LAST     = RES_W'(RESULT_TICKS - 1);
    localparam logic [8:0]        TIMEOUT_VAL  = 9'(TIMEOUT);
    localparam logic [8:0]        TIMEOUT_LAST = 9'(TIMEOUT - 1);
    localparam logic [8:0]        ACT_MIN      = 9'(ACTIVE_MIN);
    localparam logic [2:0]        CD_START     = 3'(COUNTDOWN_S);
    localparam logic [2:0]        LAST_ROUND   = 3'(NUM_ROUNDS - 1);
    localparam logic [6:0]        SUB_LAST     = 7'd99;

    state_t            state, state_nxt;
    logic [TICK_W-1:0] tick_cnt;
    logic              tick;
    logic              btn_q;
    logic              press;
    logic [6:0]        sub_cnt, sub_nxt;
    logic [8:0]        delay, delay_nxt;
    logic [8:0]        react_cnt, react_nxt;
    logic [RES_W-1:0]  res_cnt, res_nxt;
    logic [8:0]        delay_load;

    logic [2:0]  countdown_nxt;
    logic [2:0]  round_idx_nxt;
    logic [8:0]  round_score_nxt;
    logic        round_timeout_nxt;
    logic        early_nxt;
    logic [8:0]  best_nxt;
    logic [10:0] total_nxt;
    logic        cue_nxt;
    logic        done_nxt;

    assign tick  = (tick_cnt == TICK_LAST);
    assign press = btn & ~btn_q;
    assign phase = state;

    // Short LFSR values are stretched so the cue never comes sooner than ACTIVE_MIN ticks.
    assign delay_load = (lfsr_in < ACT_MIN) ? (lfsr_in + ACT_MIN) : lfsr_in;

    // The tick divider and the button history run on every clock, whatever the phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt <= '0;
            btn_q    <= 1'b0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            btn_q    <= btn;
        end
    end

    // State register plus every registered output and internal counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            sub_cnt       <= '0;
            delay         <= '0;
            react_cnt     <= '0;
            res_cnt       <= '0;
            countdown     <= '0;
            round_idx     <= '0;
            round_score   <= '0;
            round_timeout <= 1'b0;
            early         <= 1'b0;
            best_score    <= 9'h1FF;
            total_score   <= '0;
            cue           <= 1'b0;
            done          <= 1'b0;
        end else begin
            state         <= state_nxt;
            sub_cnt       <= sub_nxt;
            delay         <= delay_nxt;
            react_cnt     <= react_nxt;
            res_cnt       <= res_nxt;
            countdown     <= countdown_nxt;
            round_idx     <= round_idx_nxt;
            round_score   <= round_score_nxt;
            round_timeout <= round_timeout_nxt;
            early         <= early_nxt;
            best_score    <= best_nxt;
            total_score   <= total_nxt;
            cue           <= cue_nxt;
            done          <= done_nxt;
        end
    end

    // Next-state and next-output logic. Every value holds unless a phase event changes it.
    always_comb begin
        state_nxt         = state;
        sub_nxt           = sub_cnt;
        delay_nxt         = delay;
        react_nxt         = react_cnt;
        res_nxt           = res_cnt;
        countdown_nxt     = countdown;
        round_idx_nxt     = round_idx;
        round_score_nxt   = round_score;
        round_timeout_nxt = round_timeout;
        early_nxt         = early;
        best_nxt          = best_score;
        total_nxt         = total_score;
        cue_nxt           = cue;
        done_nxt          = done;

        case (state)
            ST_IDLE, ST_FINISHED: begin
                if (start) begin
                    state_nxt     = ST_COUNTDOWN;
                    countdown_nxt = CD_START;
                    sub_nxt       = '0;
                    round_idx_nxt = '0;
                    total_nxt     = '0;
                    early_nxt     = 1'b0;
                    best_nxt      = 9'h1FF;
                    done_nxt      = 1'b0;
                end
            end

            ST_COUNTDOWN: begin
                if (tick) begin
                    if (sub_cnt == SUB_LAST) begin
                        sub_nxt       = '0;
                        countdown_nxt = countdown - 3'd1;
                        if (countdown == 3'd1) begin
                            state_nxt = ST_WAIT;
                            delay_nxt = delay_load;
                        end
                    end else begin
                        sub_nxt = sub_cnt + 7'd1;
                    end
                end
            end

            ST_WAIT: begin
                if (press) begin
                    early_nxt = 1'b1;
`ifdef FALSE_START_PENALTY_EN
                    // The penalty counts towards the total but can never become the best score.
                    round_score_nxt   = TIMEOUT_VAL;
                    round_timeout_nxt = 1'b1;
                    total_nxt         = total_score + 11'(TIMEOUT_VAL);
                    res_nxt           = '0;
                    state_nxt         = ST_RESULT;
`else
                    state_nxt = ST_FINISHED;
                    done_nxt  = 1'b1;
`endif
                end else if (tick) begin
                    if (delay == 9'd1) begin
                        state_nxt = ST_REACT;
                        react_nxt = '0;
                        cue_nxt   = 1'b1;
                    end else begin
                        delay_nxt = delay - 9'd1;
                    end
                end
            end

            ST_REACT: begin
                // A press takes priority over a timeout tick in the same cycle.
                if (press) begin
                    round_score_nxt   = react_cnt;
                    round_timeout_nxt = 1'b0;
                    total_nxt         = total_score + 11'(react_cnt);
                    if (react_cnt < best_score) begin
                        best_nxt = react_cnt;
                    end
                    cue_nxt   = 1'b0;
                    res_nxt   = '0;
                    state_nxt = ST_RESULT;
                end else if (tick) begin
                    if (react_cnt == TIMEOUT_LAST) begin
                        round_score_nxt   = TIMEOUT_VAL;
                        round_timeout_nxt = 1'b1;
                        total_nxt         = total_score + 11'(TIMEOUT_VAL);
                        cue_nxt           = 1'b0;
                        res_nxt           = '0;
                        state_nxt         = ST_RESULT;
                    end else begin
                        react_nxt = react_cnt + 9'd1;
                    end
                end
            end

            ST_RESULT: begin
                if (tick) begin
                    if (res_cnt == RES_LAST) begin
                        if (round_idx == LAST_ROUND) begin
                            state_nxt = ST_FINISHED;
                            done_nxt  = 1'b1;
                        end else begin
                            round_idx_nxt = round_idx + 3'd1;
                            delay_nxt     = delay_load;
                            state_nxt     = ST_WAIT;
                        end
                    end else begin
                        res_nxt = res_cnt + 1'b1;
                    end
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
